change_dispenser: RTL and testbench
===================================

# change_dispenser

Returns the customer's remaining balance as coins, one coin per clock, when a return is requested or, optionally, after an idle timeout. It sits beside item_dispenser on the balance path: item_dispenser turns balance into items, change_dispenser turns balance back into coins. The balance-keeping logic subtracts `o_refund` each cycle and must not accept new coins or selections while `o_busy` is high.

## Interface
- `COIN0_VALUE`, default 100: value of coin 0, the smallest coin.
- `COIN1_VALUE`, default 500: value of coin 1.
- `COIN2_VALUE`, default 1000: value of coin 2, the largest coin. Coin values are strictly ascending.
- `TIMEOUT_CYCLES`, default 100: idle cycles before an automatic return. Used only with `AUTO_RETURN_EN`.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `i_trigger_return` input 1: return request, level-sampled.
- `i_activity` input 1: a coin was inserted or an item selected this cycle. Restarts the idle timer.
- `balance` input `kTotalBits`: current customer balance.
- `o_return_coin` output `kNumCoins` (3): one-hot coin ejected this cycle; all zero otherwise.
- `o_refund` output `kTotalBits`: value of the coin in `o_return_coin`; 0 when no coin is ejected.
- `o_busy` output 1: high while a return is in progress.
- `o_done` output 1: one-cycle pulse when a return completes.
- `o_remainder` output `kTotalBits`: undispensable residue (less than `COIN0_VALUE`) from the last return.

## Operation
- States:
  - IDLE: wait for a return request.
  - DISPENSE: eject one coin per cycle.
  - DONE: emit the completion pulse.
- Reset: state goes to IDLE. Internal `remaining`, `o_remainder` and the idle counter go to 0. All outputs are 0 in the cycle after the reset edge.
- IDLE to DISPENSE happens on a clock edge where a trigger is present:
  - a trigger is `i_trigger_return`, or a timeout (configuration only);
  - at that edge, `remaining <= balance`.
- IDLE to DONE happens instead when the trigger arrives with `balance < COIN0_VALUE`:
  - `o_remainder <= balance`;
  - no coins are ejected.
- DISPENSE, combinational outputs:
  - select the largest coin whose value is less than or equal to `remaining`;
  - `o_return_coin` is that coin's one-hot code;
  - `o_refund` is that coin's value.
- DISPENSE, at each edge:
  - `remaining <= remaining - o_refund`;
  - if the new `remaining < COIN0_VALUE`: `o_remainder <=` the new `remaining`, and go to DONE.
- DONE: `o_done` = 1 for exactly one cycle, then go to IDLE.
- `o_busy` = 1 in DISPENSE and DONE.
- Inputs ignored while busy:
  - `i_trigger_return`, `i_activity` and changes to `balance`;
  - a trigger held high across DONE does not start a second return until it is sampled in IDLE.
- Arithmetic:
  - subtraction is unsigned `kTotalBits` wide;
  - underflow is impossible by the largest-coin-that-fits rule;
  - `o_refund` summed over one return equals the latched balance minus `o_remainder`.

## Timing
- A trigger sampled at edge N produces the first coin during cycle N+1 (the cycle after the edge).
- A return of k coins occupies cycles N+1 through N+k. DONE is cycle N+k+1. IDLE resumes at N+k+2.
- A zero-coin return gives DONE at cycle N+1.
- `o_return_coin`, `o_refund` and `o_done` are decoded from registered state; they do not combinationally depend on any input.
- Reset asserted mid-DISPENSE:
  - the return aborts at that edge;
  - no `o_done` pulse;
  - coins already ejected are not reversed.

## Configuration
- Macro `VM_AUTO_RETURN_EN`.
- Defined:
  - an idle counter of `$clog2(TIMEOUT_CYCLES+1)` bits counts in IDLE while `balance != 0` and `i_activity == 0`;
  - it clears on `i_activity`, when `balance == 0`, or outside IDLE;
  - reaching `TIMEOUT_CYCLES` is a trigger at that edge, handled exactly like `i_trigger_return`;
  - the counter then clears.
- Undefined:
  - no counter;
  - only `i_trigger_return` starts a return;
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0 and `o_busy` = 0.
- `balance` = 1700, pulse `i_trigger_return` → coins 1000, 500, 100, 100 on four consecutive cycles (`o_refund` values match); then `o_done` for one cycle; `o_remainder` = 0.
- `balance` = 2650, hold the trigger high throughout → coins 1000, 1000, 500, 100; `o_remainder` = 50; exactly one `o_done`, then exactly one further return.
- `balance` = 40, trigger → no coin; `o_done` at N+1; `o_remainder` = 40.
- `balance` = 1500, trigger, then reset after the first coin → next cycle all outputs 0, state IDLE, no `o_done`.
- With `VM_AUTO_RETURN_EN`, `TIMEOUT_CYCLES` = 10, `balance` = 600:
  - pulse `i_activity` at cycle 5 → return starts 10 cycles after that pulse;
  - coins 500 then 100 are ejected.
- Without the macro, the same stimulus produces no return.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: pays out the customer's balance as coins, one coin per
// clock, greedy largest-coin-first, once a return is triggered.
// Optional feature: define VM_AUTO_RETURN_EN to also trigger a return after
// TIMEOUT_CYCLES idle cycles with a non-zero balance.
module change_dispenser #(
  parameter int unsigned COIN0_VALUE    = 100,
  parameter int unsigned COIN1_VALUE    = 500,
  parameter int unsigned COIN2_VALUE    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned kTotalBits     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_trigger_return,
  input  logic                  i_activity,
  input  logic [kTotalBits-1:0] balance,
  output logic [2:0]            o_return_coin,
  output logic [kTotalBits-1:0] o_refund,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_remainder
);

  localparam int unsigned kNumCoins = 3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  localparam logic [kTotalBits-1:0] kCoin0 = kTotalBits'(COIN0_VALUE);
  localparam logic [kTotalBits-1:0] kCoin1 = kTotalBits'(COIN1_VALUE);
  localparam logic [kTotalBits-1:0] kCoin2 = kTotalBits'(COIN2_VALUE);

  logic [1:0]            state, state_next;
  logic [kTotalBits-1:0] remaining, remaining_next;
  logic [kTotalBits-1:0] remainder_q, remainder_next;
  logic [kNumCoins-1:0]  coin_sel;
  logic [kTotalBits-1:0] coin_val;
  logic [kTotalBits-1:0] remaining_after;
  logic                  trigger;

`ifdef VM_AUTO_RETURN_EN
  localparam int unsigned kIdleBits = $clog2(TIMEOUT_CYCLES + 1);

  logic [kIdleBits-1:0] idle_cnt, idle_cnt_next;
  logic                 timeout;

  // Idle timer: counts idle cycles holding a balance; fires on reaching the limit.
  always_comb begin
    idle_cnt_next = '0;
    timeout       = 1'b0;
    if (state == ST_IDLE && balance != '0 && !i_activity) begin
      if (idle_cnt == kIdleBits'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        idle_cnt_next = idle_cnt + kIdleBits'(1);
      end
    end
  end

  // Idle timer register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_next;
    end
  end

  assign trigger = i_trigger_return | timeout;
`else
  logic unused_activity;
  assign unused_activity = i_activity;
  assign trigger         = i_trigger_return;
`endif

  // Largest coin that still fits into the remaining amount.
  always_comb begin
    coin_sel = '0;
    coin_val = '0;
    if (state == ST_DISPENSE) begin
      if (remaining >= kCoin2) begin
        coin_sel = 3'b100;
        coin_val = kCoin2;
      end else if (remaining >= kCoin1) begin
        coin_sel = 3'b010;
        coin_val = kCoin1;
      end else if (remaining >= kCoin0) begin
        coin_sel = 3'b001;
        coin_val = kCoin0;
      end
    end
  end

  assign remaining_after = remaining - coin_val;

  // Next-state and datapath update.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    remainder_next = remainder_q;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          remaining_next = balance;
          if (balance < kCoin0) begin
            remainder_next = balance;
            state_next     = ST_DONE;
          end else begin
            state_next = ST_DISPENSE;
          end
        end
      end
      ST_DISPENSE: begin
        remaining_next = remaining_after;
        if (remaining_after < kCoin0) begin
          remainder_next = remaining_after;
          state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      remainder_q <= '0;
    end else begin
      state       <= state_next;
      remaining   <= remaining_next;
      remainder_q <= remainder_next;
    end
  end

  assign o_return_coin = coin_sel;
  assign o_refund      = coin_val;
  assign o_busy        = (state != ST_IDLE);
  assign o_done        = (state == ST_DONE);
  assign o_remainder   = remainder_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy-change reference model
// queues expected coin/done events; a negedge monitor pops and compares.
module tb_change_dispenser;

  localparam int unsigned W = 16;
  localparam int unsigned T = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         trig = 1'b0;
  logic         activity = 1'b0;
  logic [W-1:0] bal = '0;
  logic [2:0]   o_return_coin;
  logic [W-1:0] o_refund;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_remainder;

  change_dispenser #(.TIMEOUT_CYCLES(T), .kTotalBits(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_trigger_return(trig),
    .i_activity(activity),
    .balance(bal),
    .o_return_coin(o_return_coin),
    .o_refund(o_refund),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_remainder(o_remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [2:0] coin;
    int       refund;
    bit       done;
    int       rem;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_left = 0;
  int   idle = 0;
  int   coins_seen = 0;
  int   dones_seen = 0;
  bit   exp_busy = 1'b0;
  bit   to_hit;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Greedy change for amount b, starting at edge index n.
  task automatic start_return(input int n, input int b);
    int cv[3] = '{100, 500, 1000};
    int r = b;
    int j = 0;
    exp_t e;
    while (r >= cv[0]) begin
      for (int i = 2; i >= 0; i--) begin
        if (cv[i] <= r) begin
          e.cyc = n + j; e.coin = 3'(1 << i); e.refund = cv[i]; e.done = 0; e.rem = 0;
          q.push_back(e);
          r -= cv[i];
          j++;
          break;
        end
      end
    end
    e.cyc = n + j; e.coin = 3'b000; e.refund = 0; e.done = 1; e.rem = r;
    q.push_back(e);
    busy_left = j + 1;
  endtask

  // Reference model: decides at each edge whether a return starts.
  always @(posedge clk) begin
    cyc++;
    to_hit = 1'b0;
    if (!reset_n) begin
      q.delete();
      busy_left = 0;
      idle = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      idle = 0;
    end else begin
`ifdef VM_AUTO_RETURN_EN
      if (activity || bal == 0) idle = 0;
      else if (idle == T - 1) begin to_hit = 1'b1; idle = 0; end
      else idle++;
`endif
      if (trig || to_hit) begin
        start_return(cyc, int'(bal));
        idle = 0;
      end
    end
    exp_busy = (busy_left > 0);
  end

  // Monitor: compares every presented coin / done pulse against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_event: expected at cycle %0d, now %0d", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    check("busy", int'(o_busy), int'(exp_busy));
    if (o_return_coin != 3'b000 || o_done) begin
      if (o_return_coin != 3'b000) coins_seen++;
      if (o_done) dones_seen++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: coin=%b refund=%0d done=%0d at cycle %0d",
                 o_return_coin, o_refund, o_done, cyc);
      end else begin
        e = q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("coin", int'(o_return_coin), int'(e.coin));
        check("refund", int'(o_refund), e.refund);
        check("done", int'(o_done), int'(e.done));
        if (e.done) check("remainder", int'(o_remainder), e.rem);
      end
    end else begin
      check("refund_idle", int'(o_refund), 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_coin"}, int'(o_return_coin), 0);
    check({tag, "_refund"}, int'(o_refund), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_done"}, int'(o_done), 0);
    check({tag, "_remainder"}, int'(o_remainder), 0);
  endtask

  initial begin
    int c0;
    int d0;
    step(3);
    reset_n = 1'b1;

    // Idle after reset.
    step(5);
    check_all_zero("reset_idle");

    // 1700: 1000, 500, 100, 100, remainder 0.
    c0 = coins_seen; d0 = dones_seen;
    bal = W'(1700); trig = 1'b1; step(1); trig = 1'b0;
    step(8);
    check("r1700_coins", coins_seen - c0, 4);
    check("r1700_dones", dones_seen - d0, 1);
    check("r1700_remainder", int'(o_remainder), 0);

    // 2650 with trigger held across the whole return: exactly two returns.
    c0 = coins_seen; d0 = dones_seen;
    bal = W'(2650); trig = 1'b1; step(7); trig = 1'b0;
    step(10);
    check("r2650_coins", coins_seen - c0, 8);
    check("r2650_dones", dones_seen - d0, 2);
    check("r2650_remainder", int'(o_remainder), 50);

    // 40: no coin, immediate done.
    c0 = coins_seen; d0 = dones_seen;
    bal = W'(40); trig = 1'b1; step(1); trig = 1'b0;
    step(3);
    check("r40_coins", coins_seen - c0, 0);
    check("r40_dones", dones_seen - d0, 1);
    check("r40_remainder", int'(o_remainder), 40);

    // 1500, reset after the first coin: abort without done.
    c0 = coins_seen; d0 = dones_seen;
    bal = W'(1500); trig = 1'b1; step(1); trig = 1'b0;
    check("abort_first_coin", int'(o_refund), 1000);
    reset_n = 1'b0; step(1); reset_n = 1'b1;
    check_all_zero("abort");
    step(3);
    check("abort_coins", coins_seen - c0, 1);
    check("abort_dones", dones_seen - d0, 0);

    // 600 with one activity pulse: auto-return only when the feature is built in.
    c0 = coins_seen;
    bal = W'(600); activity = 1'b1; step(1); activity = 1'b0;
    step(25);
`ifdef VM_AUTO_RETURN_EN
    check("timeout_coins", coins_seen - c0, 2);
`else
    check("timeout_coins", coins_seen - c0, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      trig     = ($urandom % 8) == 0;
      activity = ($urandom % 4) == 0;
      case ($urandom % 4)
        0: bal = W'($urandom_range(0, 99));
        1: bal = W'(100 * $urandom_range(0, 30));
        default: bal = W'($urandom_range(0, 5000));
      endcase
      reset_n = ($urandom % 100) != 0;
      step(1);
    end
    reset_n = 1'b1;
    trig = 1'b0; activity = 1'b0; bal = '0;
    step(30);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
